md5_result_collector: RTL and testbench

Collects 128-bit digests from an array of `md5calculator` cores and serialises them onto a single valid/ready stream tagged with the core index. Sits directly downstream of the core array and replaces per-core polling of `done`/`md5` with one arbitrated output. Each core is reported exactly once per run. A run-complete flag asserts when every core's digest has been consumed.

---
 rtl/md5_result_collector_if.sv | 28 ++
 rtl/md5_result_collector.sv | 136 +++++++++++++
 tb/tb_md5_result_collector.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_result_collector_if.sv
// md5_result_collector_if: output stream of the MD5 result collector.
// Carries one captured digest with the index of the core that produced it,
// using a plain valid/ready handshake. The collector drives the master side
// and the downstream consumer sits on the slave side.
interface md5_result_collector_if #(
    parameter int CORE_COUNT = 16
);
    localparam int IDX_WIDTH = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_WIDTH-1:0] out_index;
    logic [127:0]         out_md5;

    modport master (
        output out_valid,
        output out_index,
        output out_md5,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_md5,
        output out_ready
    );
endinterface

// File: rtl/md5_result_collector.sv
// md5_result_collector: gathers finished digests from an array of
// md5calculator cores and serialises them, one per cycle, onto a single
// valid/ready stream tagged with the core index. A round-robin pointer keeps
// any one core from starving the others, and each core is reported exactly
// once per run. 'start' begins a new run.
//
// Optional feature: define MD5_COLLECTOR_XOR_EN to build a running XOR of
// every digest handed off in the current run (xor_digest). Without it,
// xor_digest is tied to zero and no accumulator register exists.
module md5_result_collector #(
    parameter  int CORE_COUNT = 16,
    localparam int IDX_WIDTH  = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1,
    localparam int CNT_WIDTH  = IDX_WIDTH + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CORE_COUNT-1:0]     core_done,
    input  logic [128*CORE_COUNT-1:0] core_md5,
    md5_result_collector_if.master    stream,
    output logic [CNT_WIDTH-1:0]      emitted_count,
    output logic                      all_done,
    output logic [127:0]              xor_digest
);

    logic [CORE_COUNT-1:0] reported_q;
    logic [IDX_WIDTH-1:0]  rr_ptr_q;
    logic [IDX_WIDTH-1:0]  rr_ptr_d;
    logic                  out_valid_q;
    logic [IDX_WIDTH-1:0]  out_index_q;
    logic [127:0]          out_md5_q;
    logic [CNT_WIDTH-1:0]  emitted_count_q;
    logic [CNT_WIDTH-1:0]  emitted_count_d;
    logic                  all_done_q;

    logic [CORE_COUNT-1:0] eligible;
    logic                  grantValid;
    logic [IDX_WIDTH-1:0]  grantIdx;
    int                    cand;
    logic                  handshake;
    logic                  outFree;
    logic                  grantFire;
    logic [127:0]          md5Array [CORE_COUNT];

    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_slice
        assign md5Array[i] = core_md5[128*i +: 128];
    end

    assign eligible  = core_done & ~reported_q;
    assign handshake = out_valid_q & stream.out_ready;
    assign outFree   = ~out_valid_q | stream.out_ready;
    assign grantFire = grantValid & outFree & ~start;

    // Round-robin search: first eligible core at or after the pointer, wrapping.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= CORE_COUNT) begin
                cand = cand - CORE_COUNT;
            end
            if (!grantValid && eligible[IDX_WIDTH'(cand)]) begin
                grantValid = 1'b1;
                grantIdx   = IDX_WIDTH'(cand);
            end
        end
    end

    // Next pointer after a grant, and the handshake-driven emitted counter.
    always_comb begin
        rr_ptr_d = (grantIdx == IDX_WIDTH'(CORE_COUNT - 1)) ? '0 : grantIdx + IDX_WIDTH'(1);
        emitted_count_d = emitted_count_q;
        if (handshake && (emitted_count_q < CNT_WIDTH'(CORE_COUNT))) begin
            emitted_count_d = emitted_count_q + CNT_WIDTH'(1);
        end
    end

    // Output register, reported flags, pointer and run counters; start wins over all.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reported_q      <= '0;
            rr_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            out_index_q     <= '0;
            out_md5_q       <= '0;
            emitted_count_q <= '0;
            all_done_q      <= 1'b0;
        end else if (start) begin
            reported_q      <= '0;
            rr_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            emitted_count_q <= '0;
            all_done_q      <= 1'b0;
        end else begin
            emitted_count_q <= emitted_count_d;
            all_done_q      <= (emitted_count_d == CNT_WIDTH'(CORE_COUNT));
            if (grantFire) begin
                out_valid_q          <= 1'b1;
                out_index_q          <= grantIdx;
                out_md5_q            <= md5Array[grantIdx];
                reported_q[grantIdx] <= 1'b1;
                rr_ptr_q             <= rr_ptr_d;
            end else if (handshake) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef MD5_COLLECTOR_XOR_EN
    logic [127:0] xor_q;

    // Running XOR of every digest counted as handed off in this run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xor_q <= '0;
        end else if (start) begin
            xor_q <= '0;
        end else if (handshake) begin
            xor_q <= xor_q ^ out_md5_q;
        end
    end

    assign xor_digest = xor_q;
`else
    assign xor_digest = '0;
`endif

    assign stream.out_valid = out_valid_q;
    assign stream.out_index = out_index_q;
    assign stream.out_md5   = out_md5_q;
    assign emitted_count    = emitted_count_q;
    assign all_done         = all_done_q;

endmodule

// File: tb/tb_md5_result_collector.sv
// tb_md5_result_collector: randomized and directed bench for the MD5 result
// collector with four cores. A behavioural model tracks which cores have been
// reported, the arbitration pointer and the run counters; a compare process
// checks the DUT against it on every falling edge. Directed scenarios add
// hand-computed literal expectations that pin the model.
`timescale 1ns/1ps
module tb_md5_result_collector;

    localparam int CC = 4;
    localparam int IW = 2;
`ifdef MD5_COLLECTOR_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CC-1:0]     core_done = '0;
    logic [128*CC-1:0] core_md5;
    logic [127:0]      coreMd5 [CC];
    logic [IW:0]       emitted_count;
    logic              all_done;
    logic [127:0]      xor_digest;

    md5_result_collector_if #(.CORE_COUNT(CC)) stream ();

    md5_result_collector #(.CORE_COUNT(CC)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .core_done     (core_done),
        .core_md5      (core_md5),
        .stream        (stream),
        .emitted_count (emitted_count),
        .all_done      (all_done),
        .xor_digest    (xor_digest)
    );

    for (genvar i = 0; i < CC; i++) begin : g_md5
        assign core_md5[128*i +: 128] = coreMd5[i];
    end

    always #5 clock = ~clock;

    int checksTotal  = 0;
    int checksPassed = 0;
    bit compareOn    = 1'b0;

    // Behavioural model state
    bit           mValid    = 1'b0;
    int           mIdx      = 0;
    logic [127:0] mMd5      = '0;
    int           mCount    = 0;
    bit           mAllDone  = 1'b0;
    logic [127:0] mXor      = '0;
    int           mPtr      = 0;
    bit           mReported [CC];
    int           logQ [$];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checksTotal++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
        end else begin
            checksPassed++;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Model: each cycle, count a handshake, then grant the first eligible core
    // scanning circularly from the pointer whenever the output is free.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mValid = 1'b0; mIdx = 0; mMd5 = '0; mCount = 0; mAllDone = 1'b0;
            mXor = '0; mPtr = 0;
            foreach (mReported[i]) mReported[i] = 1'b0;
        end else if (start) begin
            mValid = 1'b0; mCount = 0; mAllDone = 1'b0; mXor = '0; mPtr = 0;
            foreach (mReported[i]) mReported[i] = 1'b0;
        end else begin
            bit hs;
            int grant;
            hs = mValid && (stream.out_ready === 1'b1);
            if (hs) begin
                if (mCount < CC) mCount++;
                mXor = mXor ^ mMd5;
                logQ.push_back(mIdx);
            end
            grant = -1;
            if (!mValid || hs) begin
                for (int k = 0; k < CC; k++) begin
                    int c;
                    c = (mPtr + k) % CC;
                    if (grant < 0 && core_done[c] && !mReported[c]) grant = c;
                end
            end
            if (grant >= 0) begin
                mValid = 1'b1;
                mIdx = grant;
                mMd5 = coreMd5[grant];
                mReported[grant] = 1'b1;
                mPtr = (grant + 1) % CC;
            end else if (hs) begin
                mValid = 1'b0;
            end
            mAllDone = (mCount == CC);
        end
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clock) begin
        if (compareOn) begin
            checkOutput("cmp_out_valid", 128'(stream.out_valid), 128'(mValid));
            checkOutput("cmp_emitted_count", 128'(emitted_count), 128'(mCount));
            checkOutput("cmp_all_done", 128'(all_done), 128'(mAllDone));
            checkOutput("cmp_xor_digest", xor_digest, XOR_EN ? mXor : 128'h0);
            if (mValid) begin
                checkOutput("cmp_out_index", 128'(stream.out_index), 128'(mIdx));
                checkOutput("cmp_out_md5", stream.out_md5, mMd5);
            end
        end
    end

    task automatic applyStimulus(input bit st, input logic [CC-1:0] done, input bit rdy);
        @(negedge clock);
        start = st;
        core_done = done;
        stream.out_ready = rdy;
    endtask

    initial begin
        logic [127:0] held;
        stream.out_ready = 1'b0;
        for (int i = 0; i < CC; i++) coreMd5[i] = 128'(1) << i;

        // Reset with every core done: outputs must be zero
        #1 reset = 1'b1;
        core_done = '1;
        stream.out_ready = 1'b1;
        #1 compareOn = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("rst_out_valid", 128'(stream.out_valid), 128'h0);
        checkOutput("rst_out_index", 128'(stream.out_index), 128'h0);
        checkOutput("rst_out_md5", stream.out_md5, 128'h0);
        checkOutput("rst_emitted_count", 128'(emitted_count), 128'h0);
        checkOutput("rst_all_done", 128'(all_done), 128'h0);
        checkOutput("rst_xor_digest", xor_digest, 128'h0);
        reset = 1'b0;
        for (int i = 0; i < CC; i++) begin
            @(negedge clock);
            checkOutput("seq_valid", 128'(stream.out_valid), 128'h1);
            checkOutput("seq_index", 128'(stream.out_index), 128'(i));
        end
        @(negedge clock);
        checkOutput("seq_emitted_count", 128'(emitted_count), 128'd4);
        checkOutput("seq_all_done", 128'(all_done), 128'h1);
        checkOutput("seq_valid_low", 128'(stream.out_valid), 128'h0);
        checkOutput("seq_xor_digest", xor_digest, XOR_EN ? 128'hF : 128'h0);
        checkOutput("seq_model_len", 128'(logQ.size()), 128'd4);
        if (logQ.size() == 4) begin
            checkOutput("seq_model_order0", 128'(logQ[0]), 128'd0);
            checkOutput("seq_model_order3", 128'(logQ[3]), 128'd3);
        end

        // Backpressure: only core 2 done, consumer stalls for five cycles
        applyStimulus(1'b1, 4'b0000, 1'b0);
        held = rand128();
        coreMd5[2] = held;
        applyStimulus(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("bp_valid", 128'(stream.out_valid), 128'h1);
            checkOutput("bp_index", 128'(stream.out_index), 128'd2);
            checkOutput("bp_md5", stream.out_md5, held);
        end
        stream.out_ready = 1'b1;
        @(negedge clock);
        checkOutput("bp_valid_after", 128'(stream.out_valid), 128'h0);
        checkOutput("bp_count", 128'(emitted_count), 128'd1);
        @(negedge clock);
        checkOutput("bp_count_once", 128'(emitted_count), 128'd1);

        // Round-robin wrap: core 1 first, then cores 0 and 3 together
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        logQ.delete();
        @(negedge clock);
        checkOutput("rr_first", 128'(stream.out_index), 128'd1);
        core_done = 4'b1011;
        @(negedge clock);
        checkOutput("rr_second", 128'(stream.out_index), 128'd3);
        @(negedge clock);
        checkOutput("rr_third", 128'(stream.out_index), 128'd0);
        @(negedge clock);
        checkOutput("rr_count", 128'(emitted_count), 128'd3);
        checkOutput("rr_model_len", 128'(logQ.size()), 128'd3);
        if (logQ.size() == 3) begin
            checkOutput("rr_model_order1", 128'(logQ[1]), 128'd3);
        end

        // Start mid-run: after two handshakes, restart with every core done
        applyStimulus(1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < CC; i++) coreMd5[i] = rand128();
        applyStimulus(1'b0, 4'b1111, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("st_count_before", 128'(emitted_count), 128'd2);
        start = 1'b1;
        @(negedge clock);
        checkOutput("st_valid_cleared", 128'(stream.out_valid), 128'h0);
        checkOutput("st_count_cleared", 128'(emitted_count), 128'h0);
        start = 1'b0;
        for (int i = 0; i < CC; i++) begin
            @(negedge clock);
            checkOutput("st_reemit_index", 128'(stream.out_index), 128'(i));
        end
        @(negedge clock);
        checkOutput("st_all_done", 128'(all_done), 128'h1);

        // Asynchronous reset with a digest held under backpressure
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        @(negedge clock);
        checkOutput("ar_valid_before", 128'(stream.out_valid), 128'h1);
        #2 reset = 1'b1;
        #1 checkOutput("ar_valid_dropped", 128'(stream.out_valid), 128'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ar_regrant_index", 128'(stream.out_index), 128'd0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            start = ($urandom_range(0, 99) < 3) || (all_done && ($urandom_range(0, 99) < 30));
            stream.out_ready = ($urandom_range(0, 99) < 70);
            for (int i = 0; i < CC; i++) begin
                if (core_done[i]) begin
                    if ($urandom_range(0, 99) < 3) core_done[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 15) begin
                    coreMd5[i] = rand128();
                    core_done[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 999) < 3) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        @(negedge clock);
        compareOn = 1'b0;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
